uart_port: RTL

UART_PORT -- requirements
Module: uart_port

---
 rtl/uart_port.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port.sv
// 8N1 UART behind a two-register CPU I/O window: data at BASE, control/status at BASE+1.
// Both directions are buffered by circular FIFOs; CPU strobes act on their synchronised rising edge.
module uart_port #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  BASE       = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ADDR,
    input  logic [7:0] DIN,
    input  logic       IORD,
    input  logic       IOWR,
    output logic [7:0] DOUT,
    output logic       SEL,
    output logic       UART_TX,
    input  logic       UART_RX
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [7:0] BASE_CS = BASE + 8'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Bit order in the synchroniser vectors: {UART_RX, IOWR, IORD}.
    logic [2:0] sync_m_q, sync_m_d, sync_s_q, sync_s_d;
    logic [1:0] strb_p_q, strb_p_d;

    logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];

    logic [1:0]    tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic          tx_line_q, tx_line_d, rx_brk_q, rx_brk_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;

    logic rd_end, wr_end, rx_line, sel_data, sel_ctrl;
    logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
    logic tx_tick, rx_store, ferr_set, ovr_set, sticky_clr;
    logic [7:0] tx_head, rx_head, status;

    always_comb begin
        sync_m_d = {UART_RX, IOWR, IORD};
        sync_s_d = sync_m_q;
        strb_p_d = sync_s_q[1:0];
    end

    assign rd_end   = sync_s_q[0] & ~strb_p_q[0];
    assign wr_end   = sync_s_q[1] & ~strb_p_q[1];
    assign rx_line  = sync_s_q[2];
    assign sel_data = (ADDR == BASE);
    assign sel_ctrl = (ADDR == BASE_CS);
    assign SEL      = sel_data | sel_ctrl;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];
    assign rx_head  = rx_mem_q[rx_rp_q[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tx_push  = wr_end & sel_data & (~tx_full | tx_pop);
    assign tx_flush = wr_end & sel_ctrl & DIN[0];
    assign rx_pop   = rd_end & sel_data & ~rx_empty;
    assign rx_flush = wr_end & sel_ctrl & DIN[1];
    assign rx_push  = rx_store & (~rx_full | rx_pop);
    assign ovr_set  = rx_store & rx_full & ~rx_pop;
    assign sticky_clr = (rd_end & sel_ctrl) | (wr_end & sel_ctrl & DIN[2]);

    always_comb begin
        tx_wp_d = tx_wp_q + {{AW{1'b0}}, tx_push};
        tx_rp_d = tx_flush ? tx_wp_q : tx_rp_q + {{AW{1'b0}}, tx_pop};
        rx_wp_d = rx_wp_q + {{AW{1'b0}}, rx_push};
        rx_rp_d = rx_flush ? rx_wp_d : rx_rp_q + {{AW{1'b0}}, rx_pop};
        ovr_d   = ovr_set | (ovr_q & ~sticky_clr);
        ferr_d  = ferr_set | (ferr_q & ~sticky_clr);
    end

    assign tx_tick = (tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        tx_cnt_d = (tx_st_q == S_IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        case (tx_st_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_sh_d = tx_head;
                    tx_st_d = S_START;
                end
            end
            S_START: begin
                if (tx_tick) begin
                    tx_bit_d = '0;
                    tx_st_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_sh_d  = {1'b1, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
                end
            end
            default: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        tx_sh_d = tx_head;
                        tx_st_d = S_START;
                    end else begin
                        tx_st_d = S_IDLE;
                    end
                end
            end
        endcase
        case (tx_st_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_sh_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // Receiver: START re-checks the line half a bit in to reject glitches.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_brk_d = rx_brk_q;
        rx_store = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_line) rx_st_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_line, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                end
            end
            default: begin
                if (rx_brk_q) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        rx_brk_d = 1'b0;
                        rx_st_d  = S_IDLE;
                    end
                end else if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        rx_store = 1'b1;
                        rx_st_d  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        rx_brk_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign tx_busy = (tx_st_q != S_IDLE) | ~tx_empty;
    assign status  = {3'b000, tx_busy, ferr_q, ovr_q, ~rx_empty, ~tx_full};
    assign UART_TX = tx_line_q;

    always_comb begin
        DOUT = 8'hFF;
        if (sel_data)      DOUT = rx_empty ? 8'h00 : rx_head;
        else if (sel_ctrl) DOUT = status;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_m_q  <= '1;
            sync_s_q  <= '1;
            strb_p_q  <= '1;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_line_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_brk_q  <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_m_q  <= sync_m_d;
            sync_s_q  <= sync_s_d;
            strb_p_q  <= strb_p_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_line_q <= tx_line_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_brk_q  <= rx_brk_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Byte storage and shifters carry data only and are never reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= DIN;
        if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

endmodule
